// File: rtl/dram_sched.sv
// dram_sched: DRAM cycle scheduler for the accelerator's on-board RAM.
//
// Sequences every CPU RAM access as row (ARAS), column (ACAS) and
// precharge (APRE) phases, holds RAMReady in AWAIT until the FSB cycle
// ends, and inserts CAS-before-RAS refresh cycles (RCAS, RRAS, RPRE).
// A 4-bit down-counter times the multi-cycle states: it loads N-1 on
// entry to a state and the state is left when the counter reads 0.
// Every output is registered and active-high; pin inversion happens
// at the top level.
//
// Ports:
//   CLK       FSB clock
//   RES       synchronous active-high reset
//   BACT      FSB bus cycle active (registered /AS)
//   RAMCS     current FSB cycle targets DRAM
//   nWE       FSB write strobe (0 = write)
//   nUDS/nLDS FSB byte strobes (active-low)
//   RefReq    refresh due, held until RefAck
//   RefUrg    refresh overdue; wins arbitration over a new access
//   RefAck    one-cycle pulse when a refresh sequence starts
//   RAMReady  CPU read data valid / write complete
//   RASEN     RAS strobe enable
//   CASEN     CAS strobe enable
//   RASrc     address mux select (0 = row, 1 = column)
//   UWE/LWE   upper/lower byte write enables
//   Busy      scheduler is not idle
module dram_sched #(
    parameter int RAS_CYC = 2,
    parameter int CAS_CYC = 2,
    parameter int PRE_CYC = 2,
    parameter int REF_CYC = 3
) (
    input  logic CLK,
    input  logic RES,
    input  logic BACT,
    input  logic RAMCS,
    input  logic nWE,
    input  logic nUDS,
    input  logic nLDS,
    input  logic RefReq,
    input  logic RefUrg,
    output logic RefAck,
    output logic RAMReady,
    output logic RASEN,
    output logic CASEN,
    output logic RASrc,
    output logic UWE,
    output logic LWE,
    output logic Busy
);

    typedef enum logic [2:0] {
        IDLE, ARAS, ACAS, APRE, AWAIT, RCAS, RRAS, RPRE
    } state_t;

    localparam logic [3:0] RAS_LD = 4'(RAS_CYC - 1);
    localparam logic [3:0] CAS_LD = 4'(CAS_CYC - 1);
    localparam logic [3:0] PRE_LD = 4'(PRE_CYC - 1);
    localparam logic [3:0] REF_LD = 4'(REF_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic       uwe_q, uwe_d;
    logic       lwe_q, lwe_d;
    logic       abort_q, abort_d;

    logic next_ack, next_ready, next_ras, next_cas, next_src;
    logic next_uwe, next_lwe, next_busy;

    // Next-state logic. abort remembers that BACT dropped during the
    // access so a fresh BACT seen in precharge cannot be mistaken for
    // the old cycle still waiting for data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        uwe_d   = uwe_q;
        lwe_d   = lwe_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (RefUrg) begin
                    state_d = RCAS;
                end else if (BACT && RAMCS) begin
                    state_d = ARAS;
                    cnt_d   = RAS_LD;
                    write_d = !nWE;
                    abort_d = 1'b0;
                end else if (RefReq) begin
                    state_d = RCAS;
                end
            end
            ARAS: begin
                abort_d = abort_q | !BACT;
                if (cnt_q == 4'd0) begin
                    state_d = ACAS;
                    cnt_d   = CAS_LD;
                    uwe_d   = write_q & !nUDS;
                    lwe_d   = write_q & !nLDS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACAS: begin
                abort_d = abort_q | !BACT;
                if (cnt_q == 4'd0) begin
                    state_d = APRE;
                    cnt_d   = PRE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            APRE: begin
                abort_d = abort_q | !BACT;
                if (cnt_q == 4'd0) begin
                    state_d = (BACT && !abort_q) ? AWAIT : IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            AWAIT: begin
                if (!BACT) begin
                    state_d = IDLE;
                end
            end
            RCAS: begin
                state_d = RRAS;
                cnt_d   = REF_LD;
            end
            RRAS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RPRE;
                    cnt_d   = PRE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RPRE: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode for the state being left at this edge; the result
    // is registered below, so every pin is glitch-free.
    always_comb begin
        next_ack   = 1'b0;
        next_ready = 1'b0;
        next_ras   = 1'b0;
        next_cas   = 1'b0;
        next_src   = 1'b0;
        next_uwe   = 1'b0;
        next_lwe   = 1'b0;
        next_busy  = (state_q != IDLE);
        case (state_q)
            ARAS: next_ras = 1'b1;
            ACAS: begin
                next_ras = 1'b1;
                next_cas = 1'b1;
                next_src = 1'b1;
                next_uwe = uwe_q;
                next_lwe = lwe_q;
            end
            APRE:  next_ready = BACT && !abort_q;
            AWAIT: next_ready = 1'b1;
            RCAS: begin
                next_cas = 1'b1;
                next_ack = 1'b1;
            end
            RRAS: begin
                next_cas = 1'b1;
                next_ras = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counter, latched access attributes and output registers.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            uwe_q    <= 1'b0;
            lwe_q    <= 1'b0;
            abort_q  <= 1'b0;
            RefAck   <= 1'b0;
            RAMReady <= 1'b0;
            RASEN    <= 1'b0;
            CASEN    <= 1'b0;
            RASrc    <= 1'b0;
            UWE      <= 1'b0;
            LWE      <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            uwe_q    <= uwe_d;
            lwe_q    <= lwe_d;
            abort_q  <= abort_d;
            RefAck   <= next_ack;
            RAMReady <= next_ready;
            RASEN    <= next_ras;
            CASEN    <= next_cas;
            RASrc    <= next_src;
            UWE      <= next_uwe;
            LWE      <= next_lwe;
            Busy     <= next_busy;
        end
    end

endmodule

// File: tb/tb_dram_sched.sv
// tb_dram_sched: self-checking bench for dram_sched.
//
// Each scenario is described as per-edge input tables plus an expected
// output vector per edge. The expected vectors are built from the
// timing rules of the scheduler (phase lengths, ready window, refresh
// window) with plain arithmetic, then the scenario is played edge by
// edge and the registered outputs are compared #1 after every edge.
// Output vector bit order: {RefAck, RAMReady, RASEN, CASEN, RASrc,
// UWE, LWE, Busy}.
module tb_dram_sched;

    localparam int R = 2;
    localparam int C = 2;
    localparam int P = 2;
    localparam int F = 3;
    localparam int N = 64;

    localparam int B_ACK = 7;
    localparam int B_RDY = 6;
    localparam int B_RAS = 5;
    localparam int B_CAS = 4;
    localparam int B_SRC = 3;
    localparam int B_UWE = 2;
    localparam int B_LWE = 1;
    localparam int B_BSY = 0;

    logic CLK = 1'b0;
    logic RES, BACT, RAMCS, nWE, nUDS, nLDS, RefReq, RefUrg;
    logic RefAck, RAMReady, RASEN, CASEN, RASrc, UWE, LWE, Busy;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_v [N];
    bit bact_a [N];
    bit ramcs_a [N];
    bit req_a [N];
    bit urg_a [N];
    bit res_a [N];
    bit wr_n, uds_n, lds_n;

    dram_sched #(
        .RAS_CYC(R), .CAS_CYC(C), .PRE_CYC(P), .REF_CYC(F)
    ) dut (
        .CLK(CLK), .RES(RES), .BACT(BACT), .RAMCS(RAMCS), .nWE(nWE),
        .nUDS(nUDS), .nLDS(nLDS), .RefReq(RefReq), .RefUrg(RefUrg),
        .RefAck(RefAck), .RAMReady(RAMReady), .RASEN(RASEN),
        .CASEN(CASEN), .RASrc(RASrc), .UWE(UWE), .LWE(LWE), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    function automatic void clear_scn();
        for (int k = 0; k < N; k++) begin
            exp_v[k]   = '0;
            bact_a[k]  = 1'b0;
            ramcs_a[k] = 1'b0;
            req_a[k]   = 1'b0;
            urg_a[k]   = 1'b0;
            res_a[k]   = 1'b0;
        end
        wr_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
    endfunction

    // DRAM-targeted bus cycle held active on edges from..upto-1.
    function automatic void hold_bus(int from, int upto);
        for (int k = from; k < upto; k++) begin
            bact_a[k]  = 1'b1;
            ramcs_a[k] = 1'b1;
        end
    endfunction

    // Access sampled at edge s, BACT first seen low at edge d.
    // Returns the edge at which the scheduler is idle again.
    function automatic int add_access(int s, int d, bit uw, bit lw);
        int last_cas;
        int idle;
        last_cas = s + R + C;
        for (int k = s + 1; k <= last_cas; k++) begin
            exp_v[k][B_RAS] = 1'b1;
        end
        for (int k = s + R + 1; k <= last_cas; k++) begin
            exp_v[k][B_CAS] = 1'b1;
            exp_v[k][B_SRC] = 1'b1;
            exp_v[k][B_UWE] = uw;
            exp_v[k][B_LWE] = lw;
        end
        if (d <= last_cas + P) begin
            for (int k = last_cas + 1; k < d; k++) exp_v[k][B_RDY] = 1'b1;
            idle = last_cas + P + 1;
        end else begin
            for (int k = last_cas + 1; k <= d; k++) exp_v[k][B_RDY] = 1'b1;
            idle = d + 1;
        end
        for (int k = s + 1; k < idle; k++) exp_v[k][B_BSY] = 1'b1;
        return idle;
    endfunction

    // Refresh sampled at edge s; returns the idle edge.
    function automatic int add_refresh(int s);
        exp_v[s + 1][B_ACK] = 1'b1;
        for (int k = s + 1; k <= s + 1 + F; k++) exp_v[k][B_CAS] = 1'b1;
        for (int k = s + 2; k <= s + 1 + F; k++) exp_v[k][B_RAS] = 1'b1;
        for (int k = s + 1; k <= s + F + P + 1; k++) exp_v[k][B_BSY] = 1'b1;
        return s + F + P + 2;
    endfunction

    task automatic apply_stimulus(input int k);
        RES    = res_a[k];
        BACT   = bact_a[k];
        RAMCS  = ramcs_a[k];
        RefReq = req_a[k];
        RefUrg = urg_a[k];
        nWE    = wr_n;
        nUDS   = uds_n;
        nLDS   = lds_n;
    endtask

    task automatic check_output(input string tag, input int k);
        logic [7:0] obs;
        obs = {RefAck, RAMReady, RASEN, CASEN, RASrc, UWE, LWE, Busy};
        total++;
        assert (obs === exp_v[k]) else begin
            bad++;
            $error("[TB] FAIL %s edge=%0d observed=%b expected=%b",
                   tag, k, obs, exp_v[k]);
        end
    endtask

    task automatic run_scn(input string tag, input int len);
        for (int k = 0; k <= len; k++) begin
            apply_stimulus(k);
            @(posedge CLK);
            #1;
            check_output(tag, k);
        end
    endtask

    initial begin
        int idle;
        int d;
        int kind;
        bit uw, lw;

        // Reset with everything idle: all outputs must read 0.
        clear_scn();
        res_a[0] = 1'b1;
        res_a[1] = 1'b1;
        run_scn("reset", 1);

        // Read: RASEN 1-4, CASEN/RASrc 3-4, RAMReady 5..9.
        clear_scn();
        hold_bus(0, 9);
        idle = add_access(0, 9, 1'b0, 1'b0);
        run_scn("read", idle);

        // Upper-byte write.
        clear_scn();
        wr_n = 1'b0; uds_n = 1'b0; lds_n = 1'b1;
        hold_bus(0, 7);
        idle = add_access(0, 7, 1'b1, 1'b0);
        run_scn("write_upper", idle);

        // Idle refresh.
        clear_scn();
        req_a[0] = 1'b1; req_a[1] = 1'b1;
        idle = add_refresh(0);
        run_scn("idle_refresh", idle);

        // Non-urgent contention: access first, refresh at edge 7.
        clear_scn();
        hold_bus(0, 6);
        idle = add_access(0, 6, 1'b0, 1'b0);
        for (int k = 0; k <= idle + 1; k++) req_a[k] = 1'b1;
        idle = add_refresh(idle);
        run_scn("contend_normal", idle);

        // Urgent contention: refresh first, access at 7, ready at 12.
        clear_scn();
        req_a[0] = 1'b1; req_a[1] = 1'b1;
        urg_a[0] = 1'b1; urg_a[1] = 1'b1;
        hold_bus(0, 14);
        idle = add_refresh(0);
        idle = add_access(idle, 14, 1'b0, 1'b0);
        run_scn("contend_urgent", idle);

        // Reset during ACAS, held request restarts at edge 4.
        clear_scn();
        hold_bus(0, 11);
        res_a[3] = 1'b1;
        idle = add_access(0, 11, 1'b0, 1'b0);
        for (int k = 3; k < N; k++) exp_v[k] = '0;
        idle = add_access(4, 11, 1'b0, 1'b0);
        run_scn("reset_mid", idle);

        // Randomised scenarios.
        for (int n = 0; n < 40; n++) begin
            clear_scn();
            kind  = $urandom_range(0, 4);
            wr_n  = 1'($urandom_range(0, 1));
            uds_n = 1'($urandom_range(0, 1));
            lds_n = 1'($urandom_range(0, 1));
            uw    = !wr_n && !uds_n;
            lw    = !wr_n && !lds_n;
            case (kind)
                0: begin
                    d = $urandom_range(1, R + C + P + 5);
                    hold_bus(0, d);
                    idle = add_access(0, d, uw, lw);
                    run_scn("rnd_access", idle);
                end
                1: begin
                    req_a[0] = 1'b1; req_a[1] = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        urg_a[0] = 1'b1; urg_a[1] = 1'b1;
                    end
                    idle = add_refresh(0);
                    run_scn("rnd_refresh", idle);
                end
                2: begin
                    d = $urandom_range(1, R + C + P + 5);
                    hold_bus(0, d);
                    idle = add_access(0, d, uw, lw);
                    for (int k = 0; k <= idle + 1; k++) req_a[k] = 1'b1;
                    idle = add_refresh(idle);
                    run_scn("rnd_contend", idle);
                end
                3: begin
                    d = F + P + 2 + $urandom_range(1, 8);
                    req_a[0] = 1'b1; req_a[1] = 1'b1;
                    urg_a[0] = 1'b1; urg_a[1] = 1'b1;
                    hold_bus(0, d);
                    idle = add_refresh(0);
                    idle = add_access(idle, d, uw, lw);
                    run_scn("rnd_urgent", idle);
                end
                default: begin
                    d = $urandom_range(1, 6);
                    for (int k = 0; k < d; k++) bact_a[k] = 1'b1;
                    run_scn("rnd_not_ram", d + 1);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_sched.md
# dram_sched

DRAM cycle scheduler for the accelerator's on-board RAM. It sits between the FSB cycle-detection and chip-select logic, the refresh counter and the DRAM strobe/address-mux drivers. It sequences each CPU RAM access as row, column and precharge phases and inserts CAS-before-RAS refresh cycles. CPU and refresh requests share one DRAM array: refresh is deferred in favour of CPU accesses unless it is urgent. All outputs are registered and active-high; the top level inverts them for the pins.

## Interface
- RAS_CYC, default 2, cycles RAS is held before column phase (1..15)
- CAS_CYC, default 2, cycles of column phase (1..15)
- PRE_CYC, default 2, RAS/CAS precharge cycles after any cycle (1..15)
- REF_CYC, default 3, cycles RAS held during refresh (1..15)

Ports:
- CLK  in  1  FSB clock
- RES  in  1  reset; one clock, synchronous, active-high
- BACT  in  1  FSB bus cycle active (registered /AS)
- RAMCS  in  1  current FSB cycle targets DRAM
- nWE  in  1  FSB write strobe (0 = write)
- nUDS, nLDS  in  1 each  FSB byte strobes (active-low)
- RefReq  in  1  refresh due, level, held until RefAck
- RefUrg  in  1  refresh overdue
- RefAck  out  1  one-cycle pulse, refresh sequence started
- RAMReady  out  1  CPU access data valid / write complete
- RASEN, CASEN  out  1 each  strobe enables
- RASrc  out  1  address mux select: 0 = row, 1 = column
- UWE, LWE  out  1 each  byte write enables
- Busy  out  1  state != IDLE

## Operation
- States: IDLE, ARAS, ACAS, APRE, AWAIT, RCAS, RRAS, RPRE. A 4-bit down-counter times each multi-cycle state.
- The counter loads N-1 on entry to a state and leaves the state when it reads 0.
- IDLE:
  - If RefUrg: go to RCAS.
  - Else if BACT&RAMCS: go to ARAS and latch write = !nWE.
  - Else if RefReq: go to RCAS.
  - Arbitration outcome: a new access beats a non-urgent refresh; an urgent refresh beats a new access.
- ARAS (RAS_CYC): RASEN=1, RASrc=0.
- ACAS (CAS_CYC):
  - RASEN=1, CASEN=1, RASrc=1.
  - On entry, latch UWE=write&!nUDS and LWE=write&!nLDS; hold them for the whole of ACAS.
- APRE (PRE_CYC): all strobes 0.
  - RAMReady=BACT.
  - On exit, go to AWAIT if BACT is still high, else IDLE.
- AWAIT: RAMReady=1; go to IDLE when BACT=0.
  - Guarantees one request produces exactly one access, because IDLE never sees a stale BACT.
- An access that has started is never preempted; RAMCS and RefUrg are ignored until IDLE.
- BACT falling mid-access (abort): the strobe sequence still completes, RAMReady stays 0, and the FSM skips AWAIT.
- RCAS (1 cycle): CASEN=1, RASEN=0, RefAck=1.
- RRAS (REF_CYC): CASEN=1, RASEN=1.
- RPRE (PRE_CYC): all 0, then IDLE.
- UWE/LWE are 0 in every state except ACAS.
- RES: at the next edge the FSM goes to IDLE, the counter is cleared and every output is 0. This applies from any state, including mid-strobe. No RefAck is issued for an aborted refresh; RefReq stays pending.

## Timing
- Reset value of every output is 0.
- Edge numbering: edge 0 is the edge at which IDLE samples the request; edges below are relative to it.
- Access:
  - ARAS: edges 1..RAS_CYC.
  - ACAS: edges RAS_CYC+1..RAS_CYC+CAS_CYC.
  - RAMReady first high at edge RAS_CYC+CAS_CYC+1 (5 with defaults).
  - It stays high until the edge after BACT is sampled low.
- Minimum access-to-next-access: RAS_CYC+CAS_CYC+PRE_CYC+1 edges. The next access starts at the first IDLE edge with BACT high.
- Refresh:
  - RefAck and RCAS at edge 1.
  - RRAS: edges 2..REF_CYC+1.
  - RPRE: next PRE_CYC edges.
  - IDLE at edge REF_CYC+PRE_CYC+2 (7 with defaults).
- RASEN rises no earlier than one cycle after CASEN in refresh. CASEN never asserts without RASEN during an access.

## Test plan
Defaults apply throughout; edge numbers are relative to the request sample edge 0.
- Read:
  - Stimulus: BACT=RAMCS=1, nWE=1 at edge 0.
  - Response: RASEN edges 1-4; CASEN and RASrc edges 3-4; RAMReady high from edge 5 until BACT drops; UWE=LWE=0 throughout.
- Upper-byte write:
  - Stimulus: nWE=0, nUDS=0, nLDS=1.
  - Response: UWE=1 edges 3-4; LWE=0 throughout; RAMReady at edge 5.
- Idle refresh:
  - Stimulus: RefReq=1.
  - Response: RefAck pulse at edge 1; CASEN edges 1-4; RASEN edges 2-4; outputs 0 at edges 5-6; Busy=0 at edge 7.
- Non-urgent contention:
  - Stimulus: RefReq and access together at edge 0.
  - Response: RAMReady at edge 5; BACT dropped at edge 6 gives IDLE at 7; RefAck at edge 8.
- Urgent contention:
  - Stimulus: RefUrg, RefReq and access together at edge 0.
  - Response: RefAck at edge 1; IDLE at edge 7; RAMReady at edge 12.
- Reset mid-cycle:
  - Stimulus: RES pulsed at edge 3 (during ACAS).
  - Response: all outputs 0 at edge 4. A held request restarts cleanly once RES is low, and RAMReady is then seen exactly once.
